move_apply: RTL

MOVE_APPLY -- requirements
Module: move_apply

---
 rtl/move_apply_pkg.sv | 19 +
 rtl/move_apply_if.sv | 33 +++
 rtl/move_apply.sv | 97 +++++++++
 3 files changed

// File: rtl/move_apply_pkg.sv
// Shared chess encoding: square nibble layout and piece-type codes,
// used by the move applier and the check detector.
package move_apply_pkg;

  localparam int NIBBLE_W  = 4;
  localparam int TYPE_W    = 3;
  localparam int COLOR_BIT = 3;

  localparam logic [TYPE_W-1:0] PIECE_EMPTY = 3'b000;
  localparam logic [TYPE_W-1:0] PIECE_KING  = 3'b001;
  localparam logic [TYPE_W-1:0] PIECE_ROOK  = 3'b101;

  function automatic logic is_piece(input logic [NIBBLE_W-1:0] nib,
                                    input logic [TYPE_W-1:0]   code,
                                    input logic                color);
    return (nib[TYPE_W-1:0] == code) && (nib[COLOR_BIT] == color);
  endfunction

endpackage

// File: rtl/move_apply_if.sv
// Load/move request and scan result bundle between the move applier and its client.
interface move_apply_if
  import move_apply_pkg::*;
#(
  parameter int SQUARES = 64
) ();

  localparam int IDX_W   = $clog2(SQUARES);
  localparam int BOARD_W = SQUARES * NIBBLE_W;

  logic               loadValid;
  logic [BOARD_W-1:0] loadBoard;
  logic               moveValid;
  logic [IDX_W-1:0]   moveFrom;
  logic [IDX_W-1:0]   moveTo;
  logic               kingColor;
  logic               ready;
  logic [BOARD_W-1:0] bigBoard;
  logic [IDX_W-1:0]   currentPosition;
  logic               doneValid;
  logic               kingFound;

  modport master (
    output loadValid, loadBoard, moveValid, moveFrom, moveTo, kingColor,
    input  ready, bigBoard, currentPosition, doneValid, kingFound
  );

  modport slave (
    input  loadValid, loadBoard, moveValid, moveFrom, moveTo, kingColor,
    output ready, bigBoard, currentPosition, doneValid, kingFound
  );

endinterface

// File: rtl/move_apply.sv
// Applies a move to the registered board, then scans square by square for
// the king of the requested colour and reports where it was found.
module move_apply
  import move_apply_pkg::*;
#(
  parameter logic [TYPE_W-1:0] KING_CODE = PIECE_KING,
  parameter int                SQUARES   = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  move_apply_if.slave  bus
);

  localparam int IDX_W   = $clog2(SQUARES);
  localparam int BOARD_W = SQUARES * NIBBLE_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SQUARES - 1);

  typedef enum logic [1:0] {IDLE, APPLY, SCAN, DONE} state_t;

  state_t              state;
  logic [BOARD_W-1:0]  board;
  logic [IDX_W-1:0]    from_q;
  logic [IDX_W-1:0]    to_q;
  logic [IDX_W-1:0]    scan_idx;
  logic [IDX_W-1:0]    cur_pos;
  logic                color_q;
  logic                ready_q;
  logic                done_q;
  logic                found_q;
  logic [NIBBLE_W-1:0] scan_nib;

  assign scan_nib = board[int'(scan_idx)*NIBBLE_W +: NIBBLE_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      board    <= '0;
      from_q   <= '0;
      to_q     <= '0;
      scan_idx <= '0;
      cur_pos  <= '0;
      color_q  <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.loadValid) begin
            board <= bus.loadBoard;
          end else if (bus.moveValid) begin
            from_q  <= bus.moveFrom;
            to_q    <= bus.moveTo;
            color_q <= bus.kingColor;
            ready_q <= 1'b0;
            state   <= APPLY;
          end
        end
        APPLY: begin
          // A null move must not clear its own square, so skip the write pair.
          if (from_q != to_q) begin
            board[int'(to_q)*NIBBLE_W +: NIBBLE_W]   <= board[int'(from_q)*NIBBLE_W +: NIBBLE_W];
            board[int'(from_q)*NIBBLE_W +: NIBBLE_W] <= {1'b0, PIECE_EMPTY};
          end
          scan_idx <= '0;
          state    <= SCAN;
        end
        SCAN: begin
          if (is_piece(scan_nib, KING_CODE, color_q)) begin
            cur_pos <= scan_idx;
            found_q <= 1'b1;
            state   <= DONE;
          end else if (scan_idx == LAST_IDX) begin
            found_q <= 1'b0;
            state   <= DONE;
          end else begin
            scan_idx <= scan_idx + 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready           = ready_q;
  assign bus.bigBoard        = board;
  assign bus.currentPosition = cur_pos;
  assign bus.doneValid       = done_q;
  assign bus.kingFound       = found_q;

endmodule
